ccd_clock_sequencer: RTL

Wishbone-configurable CCD phase-clock sequencer that drives the CCD readout strobes phi_p, phi_l1, phi_l2 and phi_r. It is the parametrised successor of the fixed-timing signal generator. Pixel count, reset-pulse width, hold time and phase-step length are runtime registers, and it adds one-shot mode, a frame counter and a frame-done strobe. It sits on the user-project Wishbone bus and drives the CCD pads directly.

---
 rtl/ccd_clock_sequencer.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/ccd_clock_sequencer.sv
// CCD phase-clock sequencer with a Wishbone register block.
// Drives phi_p / phi_l1 / phi_l2 / phi_r through PULSE -> SHIFT -> HOLD frames
// with runtime pixel count, pulse width, hold time and step divider.
module ccd_clock_sequencer #(
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int          CNT_W        = 14,
  parameter int          DEFAULT_NPIX = 2052,
  parameter int          DEFAULT_PW   = 18,
  parameter logic [31:0] DEFAULT_TINT = 32'h1009
) (
  input  logic        i_wb_clk,
  input  logic        i_wb_rst,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_ack,
  output logic [31:0] o_wb_data,
  output logic        o_phi_p,
  output logic        o_phi_l1,
  output logic        o_phi_l2,
  output logic        o_phi_r,
  output logic        o_frame_done,
  output logic        o_busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, PULSE = 2'd1, SHIFT = 2'd2, HOLD = 2'd3} state_t;

  localparam logic [CNT_W-1:0] NPIX_RST = CNT_W'(DEFAULT_NPIX);
  localparam logic [15:0]      PW_RST   = 16'(DEFAULT_PW);
  localparam logic [CNT_W-1:0] PIX_ONE  = CNT_W'(1);

  // Bus-side registers
  logic             ack_q, ack_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             en_q, en_d, oneshot_q, oneshot_d, start_q, start_d;
  logic [CNT_W-1:0] npix_q, npix_d;
  logic [31:0]      tint_q, tint_d;
  logic [15:0]      pw_q, pw_d;
  logic [7:0]       div_q, div_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  // Sequencer state, per-frame shadow copies and counters
  state_t           state_q, state_d;
  logic [1:0]       step_q, step_d;
  logic [CNT_W-1:0] pix_q, pix_d;
  logic [31:0]      cyc_q, cyc_d;
  logic [CNT_W-1:0] sh_npix_q, sh_npix_d;
  logic [31:0]      sh_tint_q, sh_tint_d;
  logic [15:0]      sh_pw_q, sh_pw_d;
  logic [7:0]       sh_div_q, sh_div_d;

  // Registered outputs
  logic phi_p_q, phi_p_d, phi_l1_q, phi_l1_d, phi_l2_q, phi_l2_d, phi_r_q, phi_r_d;
  logic done_q, done_d, busy_q, busy_d;

  logic        wb_req, wb_hit;
  logic [31:0] wb_off;
  logic [2:0]  wb_sel;
  logic        load_shadow;
  logic [15:0] pw_last;
  logic [31:0] tint_last;

  assign wb_req = i_wb_cyc & i_wb_stb & ~ack_q;
  assign wb_off = i_wb_addr - BASE_ADDR;
  assign wb_hit = (wb_off[31:5] == 27'd0) && (wb_off[1:0] == 2'd0);
  assign wb_sel = wb_off[4:2];

  // Zero pulse/hold lengths behave as one cycle.
  assign pw_last   = (sh_pw_q == 16'd0)   ? 16'd0 : sh_pw_q - 16'd1;
  assign tint_last = (sh_tint_q == 32'd0) ? 32'd0 : sh_tint_q - 32'd1;

  // Register file: decode writes, build registered read data and ack.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    ack_d     = wb_req;
    rdata_d   = 32'd0;
    en_d      = en_q;
    oneshot_d = oneshot_q;
    start_d   = 1'b0;
    npix_d    = npix_q;
    tint_d    = tint_q;
    pw_d      = pw_q;
    div_d     = div_q;
    if (wb_req && wb_hit) begin
      if (i_wb_we) begin
        case (wb_sel)
          3'd0: begin
            en_d      = i_wb_data[0];
            oneshot_d = i_wb_data[1];
            start_d   = i_wb_data[2];
          end
          3'd1:    npix_d = i_wb_data[CNT_W-1:0];
          3'd2:    tint_d = i_wb_data;
          3'd3:    pw_d   = i_wb_data[15:0];
          3'd4:    div_d  = i_wb_data[7:0];
          default: ;
        endcase
      end else begin
        case (wb_sel)
          3'd0:    rdata_d = {30'd0, oneshot_q, en_q};
          3'd1:    rdata_d = 32'(npix_q);
          3'd2:    rdata_d = tint_q;
          3'd3:    rdata_d = {16'd0, pw_q};
          3'd4:    rdata_d = {24'd0, div_q};
          3'd5:    rdata_d = {frame_cnt_q, 13'd0, state_q, busy_q};
          default: rdata_d = 32'd0;
        endcase
      end
    end
  end

  // Sequencer next state, counters, shadow loads and next-cycle phase outputs.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    pix_d       = pix_q;
    cyc_d       = cyc_q;
    frame_cnt_d = frame_cnt_q;
    done_d      = 1'b0;
    load_shadow = 1'b0;
    if (!en_q) begin
      state_d = IDLE;
      step_d  = 2'd0;
      pix_d   = '0;
      cyc_d   = 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!oneshot_q || start_q) begin
            state_d     = PULSE;
            cyc_d       = 32'd0;
            load_shadow = 1'b1;
          end
        end
        PULSE: begin
          if (cyc_q == {16'd0, pw_last}) begin
            cyc_d   = 32'd0;
            step_d  = 2'd0;
            pix_d   = '0;
            state_d = (sh_npix_q == '0) ? HOLD : SHIFT;
          end else begin
            cyc_d = cyc_q + 32'd1;
          end
        end
        SHIFT: begin
          if (cyc_q == {24'd0, sh_div_q}) begin
            cyc_d = 32'd0;
            if (step_q == 2'd3) begin
              step_d = 2'd0;
              if (pix_q == sh_npix_q - PIX_ONE) begin
                pix_d   = '0;
                state_d = HOLD;
              end else begin
                pix_d = pix_q + PIX_ONE;
              end
            end else begin
              step_d = step_q + 2'd1;
            end
          end else begin
            cyc_d = cyc_q + 32'd1;
          end
        end
        HOLD: begin
          if (cyc_q == tint_last) begin
            cyc_d       = 32'd0;
            done_d      = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (oneshot_q) begin
              state_d = IDLE;
            end else begin
              state_d     = PULSE;
              load_shadow = 1'b1;
            end
          end else begin
            cyc_d = cyc_q + 32'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    sh_npix_d = load_shadow ? npix_q : sh_npix_q;
    sh_tint_d = load_shadow ? tint_q : sh_tint_q;
    sh_pw_d   = load_shadow ? pw_q   : sh_pw_q;
    sh_div_d  = load_shadow ? div_q  : sh_div_q;

    // Outputs follow the state being entered so they are valid from its first cycle.
    phi_p_d  = 1'b0;
    phi_l1_d = 1'b0;
    phi_l2_d = 1'b0;
    phi_r_d  = 1'b0;
    case (state_d)
      PULSE: begin
        phi_p_d  = 1'b1;
        phi_l2_d = 1'b1;
        phi_r_d  = 1'b1;
      end
      SHIFT: begin
        phi_r_d  = (step_d == 2'd0);
        phi_l2_d = ~step_d[1];
        phi_l1_d = step_d[1];
      end
      default: ;
    endcase
    busy_d = (state_d != IDLE);
  end

  // All state registers with synchronous reset.
  always_ff @(posedge i_wb_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (i_wb_rst) begin
      ack_q       <= 1'b0;
      rdata_q     <= 32'd0;
      en_q        <= 1'b0;
      oneshot_q   <= 1'b0;
      start_q     <= 1'b0;
      npix_q      <= NPIX_RST;
      tint_q      <= DEFAULT_TINT;
      pw_q        <= PW_RST;
      div_q       <= 8'd0;
      frame_cnt_q <= 16'd0;
      state_q     <= IDLE;
      step_q      <= 2'd0;
      pix_q       <= '0;
      cyc_q       <= 32'd0;
      sh_npix_q   <= NPIX_RST;
      sh_tint_q   <= DEFAULT_TINT;
      sh_pw_q     <= PW_RST;
      sh_div_q    <= 8'd0;
      phi_p_q     <= 1'b0;
      phi_l1_q    <= 1'b0;
      phi_l2_q    <= 1'b0;
      phi_r_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      en_q        <= en_d;
      oneshot_q   <= oneshot_d;
      start_q     <= start_d;
      npix_q      <= npix_d;
      tint_q      <= tint_d;
      pw_q        <= pw_d;
      div_q       <= div_d;
      frame_cnt_q <= frame_cnt_d;
      state_q     <= state_d;
      step_q      <= step_d;
      pix_q       <= pix_d;
      cyc_q       <= cyc_d;
      sh_npix_q   <= sh_npix_d;
      sh_tint_q   <= sh_tint_d;
      sh_pw_q     <= sh_pw_d;
      sh_div_q    <= sh_div_d;
      phi_p_q     <= phi_p_d;
      phi_l1_q    <= phi_l1_d;
      phi_l2_q    <= phi_l2_d;
      phi_r_q     <= phi_r_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign o_wb_ack     = ack_q;
  assign o_wb_data    = rdata_q;
  assign o_phi_p      = phi_p_q;
  assign o_phi_l1     = phi_l1_q;
  assign o_phi_l2     = phi_l2_q;
  assign o_phi_r      = phi_r_q;
  assign o_frame_done = done_q;
  assign o_busy       = busy_q;

endmodule
